// File: rtl/dcache_fill_pkg.sv
// Shared constants, FSM state codes and the big-endian word selector for the
// direct-mapped read-only data cache.
package dcache_fill_pkg;

  localparam int BYTE_SIZE       = 8;
  localparam int WORD_SIZE       = 32;
  localparam int BLOCK_SIZE      = 128;
  localparam int WORDS_PER_BLOCK = BLOCK_SIZE / WORD_SIZE;
  localparam int OFF_W           = $clog2(BLOCK_SIZE / BYTE_SIZE);
  localparam int WSEL_W          = $clog2(WORDS_PER_BLOCK);
  localparam int BSEL_W          = $clog2(WORD_SIZE / BYTE_SIZE);

  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_FILL = 2'd1,
    DC_RESP = 2'd2
  } dc_state_t;

  // Word 0 sits in the most significant bits of the line.
  function automatic logic [WORD_SIZE-1:0] word_sel(input logic [BLOCK_SIZE-1:0] blk,
                                                    input logic [WSEL_W-1:0]     w);
    logic [BLOCK_SIZE-1:0] sh;
    sh = blk << (int'(w) * WORD_SIZE);
    return sh[BLOCK_SIZE-1 -: WORD_SIZE];
  endfunction

endpackage

// File: rtl/dcache_fill_if.sv
// CPU load port, datamem port, statistics and FSM debug view of dcache_fill.
interface dcache_fill_if;
  import dcache_fill_pkg::*;

  // Handshake: cpu_req is held with a stable cpu_addr until cpu_ready pulses
  // for one cycle with cpu_data valid; a request still high after that is new.
  logic                  cpu_req;
  logic [WORD_SIZE-1:0]  cpu_addr;
  logic                  cpu_ready;
  logic [WORD_SIZE-1:0]  cpu_data;
  logic                  flush;
  logic                  busy;
  logic [BYTE_SIZE-1:0]  mem_addr;
  logic [BLOCK_SIZE-1:0] mem_block;
  logic [15:0]           hit_cnt;
  logic [15:0]           miss_cnt;
  dc_state_t             dbg_state;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_block,
    output cpu_ready, cpu_data, busy, mem_addr, hit_cnt, miss_cnt, dbg_state
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_block,
    input  cpu_ready, cpu_data, busy, mem_addr, hit_cnt, miss_cnt, dbg_state
  );

endinterface

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage: combinational read by index, synchronous write,
// clear-all of valid bits. Only the valid bits are reset.
module dcache_line_array
  import dcache_fill_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 24,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_all,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [BLOCK_SIZE-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [BLOCK_SIZE-1:0] i_wr_data
);

  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [BLOCK_SIZE-1:0] r_data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr_all) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_fill.sv
// Direct-mapped read-only data cache between the CPU load port and datamem.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_fill
  import dcache_fill_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  dcache_fill_if.slave s_bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  dc_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ready;
  logic [WORD_SIZE-1:0]  r_data;
  logic [BYTE_SIZE-1:0]  r_mem_addr;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [WSEL_W-1:0]     w_wsel;
  logic                  w_rd_valid;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [BLOCK_SIZE-1:0] w_rd_data;
  logic                  w_hit;
  logic                  w_flush_all, w_hit_resp, w_fill_start, w_fill_done, w_fill_resp;
  logic                  w_unused;

  assign w_idx    = s_bus.cpu_addr[OFF_W +: IDX_W];
  assign w_tag    = s_bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign w_wsel   = s_bus.cpu_addr[BSEL_W +: WSEL_W];
  assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
  assign w_unused = ^s_bus.cpu_addr[BSEL_W-1:0];

  dcache_line_array #(.LINES(LINES), .TAG_W(TAG_W)) u_lines (
    .clk        (clk),
    .rst        (rst),
    .i_clr_all  (w_flush_all),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill_done),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_data  (s_bus.mem_block)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DC_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_flush_all  = 1'b0;
    w_hit_resp   = 1'b0;
    w_fill_start = 1'b0;
    w_fill_done  = 1'b0;
    w_fill_resp  = 1'b0;
    case (r_state)
      DC_IDLE: begin
        // flush wins; a simultaneous request is picked up next cycle
        if (s_bus.flush) begin
          w_flush_all = 1'b1;
        end else if (s_bus.cpu_req) begin
          if (w_hit) begin
            w_hit_resp = 1'b1;
          end else begin
            w_fill_start = 1'b1;
            w_state_nxt  = DC_FILL;
          end
        end
      end
      DC_FILL: begin
        if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
          w_fill_done = 1'b1;
          w_state_nxt = DC_RESP;
        end
      end
      DC_RESP: begin
        w_fill_resp = 1'b1;
        w_state_nxt = DC_IDLE;
      end
      default: w_state_nxt = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_data     <= '0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
    end else begin
      r_ready <= w_hit_resp | w_fill_resp;
      if (w_hit_resp || w_fill_resp) r_data <= word_sel(w_rd_data, w_wsel);
      if (w_fill_start) begin
        r_mem_addr <= {s_bus.cpu_addr[BYTE_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        r_cnt      <= '0;
      end else if (r_state == DC_FILL) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_resp && r_hit_cnt != 16'hFFFF)    r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_fill_start && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign s_bus.hit_cnt  = r_hit_cnt;
  assign s_bus.miss_cnt = r_miss_cnt;
`else
  assign s_bus.hit_cnt  = 16'd0;
  assign s_bus.miss_cnt = 16'd0;
`endif

  assign s_bus.cpu_ready = r_ready;
  assign s_bus.cpu_data  = r_data;
  assign s_bus.mem_addr  = r_mem_addr;
  assign s_bus.busy      = (r_state != DC_IDLE);
  assign s_bus.dbg_state = r_state;

endmodule

// File: tb/tb_dcache_fill.sv
// Directed bench for dcache_fill with a datamem model whose byte k holds k.
// Counter expectations follow DCACHE_STATS_EN.
module tb_dcache_fill;
  import dcache_fill_pkg::*;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  bit   ready_seen;

  dcache_fill_if bus_if ();

  dcache_fill #(.LINES(16), .MEM_LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus_if)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BLOCK_SIZE-1:0] mem_line(input logic [BYTE_SIZE-1:0] a);
    logic [BLOCK_SIZE-1:0] blk;
    blk = '0;
    for (int i = 0; i < BLOCK_SIZE / BYTE_SIZE; i++) begin
      blk[BLOCK_SIZE-1-i*BYTE_SIZE -: BYTE_SIZE] = a + BYTE_SIZE'(i);
    end
    return blk;
  endfunction

  always @(posedge clk) bus_if.mem_block <= mem_line(bus_if.mem_addr);

  function automatic logic [31:0] exp_cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: issue one load, wait for cpu_ready within a bounded budget
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_lat, input bit flush_mid);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = a;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (flush_mid) bus_if.flush = (lat == 1);
      if (bus_if.cpu_ready) got = 1'b1;
    end
    bus_if.flush   = 1'b0;
    bus_if.cpu_req = 1'b0;
    check({tag, "_ready"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, bus_if.cpu_data, exp_d);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int hits, input int misses);
    check({tag, "_hit_cnt"}, 32'(bus_if.hit_cnt), exp_cnt(hits));
    check({tag, "_miss_cnt"}, 32'(bus_if.miss_cnt), exp_cnt(misses));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_addr  = '0;
    bus_if.flush     = 1'b0;
    bus_if.mem_block = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus_if.cpu_ready), 32'd0);
    check("rst_data", bus_if.cpu_data, 32'd0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_state", 32'(bus_if.dbg_state), 32'(DC_IDLE));
    check("rst_hit_cnt", 32'(bus_if.hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(bus_if.miss_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // cold miss, then hits in the same line
    do_load("cold", 32'h10, 32'h10111213, 4, 1'b0);
    check("cold_mem_addr", 32'(bus_if.mem_addr), 32'h10);
    check_counts("cold", 0, 1);
    do_load("hit14", 32'h14, 32'h14151617, 1, 1'b0);
    check("hit14_mem_addr", 32'(bus_if.mem_addr), 32'h10);
    check_counts("hit14", 1, 1);
    do_load("hit1c", 32'h1C, 32'h1C1D1E1F, 1, 1'b0);

    // conflict eviction on index 1; upper address bits live only in the tag
    do_load("conf110", 32'h110, 32'h10111213, 4, 1'b0);
    check("conf110_mem_addr", 32'(bus_if.mem_addr), 32'h10);
    do_load("conf10", 32'h10, 32'h10111213, 4, 1'b0);
    do_load("idx15", 32'hF8, 32'hF8F9FAFB, 4, 1'b0);
    check("idx15_mem_addr", 32'(bus_if.mem_addr), 32'hF0);
    do_load("idx1_hit", 32'h10, 32'h10111213, 1, 1'b0);
    check_counts("conf", 3, 4);

    // flush while filling is ignored
    do_load("fl_fill", 32'h20, 32'h20212223, 4, 1'b1);
    do_load("fl_fill_hit", 32'h20, 32'h20212223, 1, 1'b0);

    // flush and request in the same IDLE cycle
    bus_if.flush    = 1'b1;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h10;
    @(posedge clk);
    #1;
    check("flpri_noready", 32'(bus_if.cpu_ready), 32'd0);
    check("flpri_busy", 32'(bus_if.busy), 32'd0);
    bus_if.flush = 1'b0;
    do_load("flpri", 32'h10, 32'h10111213, 4, 1'b0);
    do_load("flpri_20", 32'h20, 32'h20212223, 4, 1'b0);
    check_counts("flpri", 4, 7);

    // reset during FILL
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 32'h30;
    @(posedge clk);
    #1;
    check("rmid_busy_fill", 32'(bus_if.busy), 32'd1);
    check("rmid_state_fill", 32'(bus_if.dbg_state), 32'(DC_FILL));
    ready_seen = bus_if.cpu_ready;
    rst = 1'b1;
    #1;
    check("rmid_busy", 32'(bus_if.busy), 32'd0);
    bus_if.cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      ready_seen = ready_seen | bus_if.cpu_ready;
      if (i == 1) rst = 1'b0;
    end
    check("rmid_no_ready", 32'(ready_seen), 32'd0);
    check("rmid_mem_addr", 32'(bus_if.mem_addr), 32'd0);
    check_counts("rmid", 0, 0);
    @(negedge clk);
    do_load("rmid_re10", 32'h10, 32'h10111213, 4, 1'b0);
    do_load("rmid_re30", 32'h30, 32'h30313233, 4, 1'b0);
    check_counts("rmid_re", 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
